// File: rtl/load_store_unit.sv
// load_store_unit: turns RV32I byte-addressed loads/stores into word accesses
// on a single-port, word-addressed data memory with no byte enables.
// Sub-word stores are a read-modify-write. Misaligned or illegal requests
// are answered with rsp_err and never reach the memory.
//
// Handshake: a request is taken on a rising edge where req_valid & req_ready.
// req_ready is high only in IDLE. The response is a single-cycle rsp_valid
// pulse with no backpressure. rsp_rdata/rsp_err hold until the next response.
module load_store_unit #(
    parameter int ADDR_W   = 10,
    parameter int DATA_LEN = 32
) (
    input  logic                d_clk,
    input  logic                d_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [DATA_LEN-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [DATA_LEN-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_LEN-1:0] mem_w_data,
    output logic                mem_rw_en,
    output logic                mem_cs,
    input  logic [DATA_LEN-1:0] mem_r_data,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_DATA = 3'd2,
        S_RMW_RD  = 3'd3,
        S_MERGE   = 3'd4,
        S_WR      = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_LEN-1:0] mem_w_data_q, mem_w_data_d;
    logic                mem_cs_q, mem_cs_d;
    logic                mem_rw_en_q, mem_rw_en_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_LEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    // Address bits above the memory's word range are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Misaligned halves/words and unknown funct3 encodings are rejected.
    function automatic logic is_bad(input logic we, input logic [2:0] f3,
                                    input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'b000, 3'b100: bad = we && (f3 == 3'b100);
            3'b001, 3'b101: bad = a[0] || (we && (f3 == 3'b101));
            3'b010:         bad = (a != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Picks the addressed lane out of a memory word and extends it.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Overwrites the addressed byte/half of the old word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [31:0] d,
                                                input logic [2:0] f3,
                                                input logic [1:0] a);
        logic [31:0] r;
        r = w;
        if (f3 == 3'b000) begin
            case (a)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else if (a[1]) begin
            r[31:16] = d[15:0];
        end else begin
            r[15:0] = d[15:0];
        end
        return r;
    endfunction

    // Next-state and next-output logic; memory and response outputs are
    // computed one state ahead so they come straight from flops.
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_w_data_d = mem_w_data_q;
        mem_cs_d     = 1'b0;
        mem_rw_en_d  = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    off_d      = req_addr[1:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = req_addr[ADDR_W+1:2];
                    if (is_bad(req_we, req_funct3, req_addr[1:0])) begin
                        state_d = S_ERR;
                    end else if (!req_we) begin
                        state_d  = S_RD;
                        mem_cs_d = 1'b1;
                    end else if (req_funct3 == 3'b010) begin
                        state_d      = S_WR;
                        mem_cs_d     = 1'b1;
                        mem_rw_en_d  = 1'b1;
                        mem_w_data_d = req_wdata;
                    end else begin
                        state_d  = S_RMW_RD;
                        mem_cs_d = 1'b1;
                    end
                end
            end
            S_RD:      state_d = S_RD_DATA;
            S_RD_DATA: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = load_extract(mem_r_data, funct3_q, off_q);
            end
            S_RMW_RD:  state_d = S_MERGE;
            S_MERGE: begin
                state_d      = S_WR;
                mem_cs_d     = 1'b1;
                mem_rw_en_d  = 1'b1;
                mem_w_data_d = store_merge(mem_r_data, wdata_q, funct3_q, off_q);
            end
            S_WR: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            S_ERR: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // All state, with asynchronous reset that aborts any access in flight.
    always_ff @(posedge d_clk or posedge d_rst) begin
        if (d_rst) begin
            state_q      <= S_IDLE;
            funct3_q     <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_w_data_q <= '0;
            mem_cs_q     <= 1'b0;
            mem_rw_en_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
            mem_cs_q     <= mem_cs_d;
            mem_rw_en_q  <= mem_rw_en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_w_data = mem_w_data_q;
    assign mem_rw_en  = mem_rw_en_q;
    assign mem_cs     = mem_cs_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural registered-read memory.
module tb_load_store_unit;

    logic        d_clk = 1'b0;
    logic        d_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_w_data;
    logic        mem_rw_en;
    logic        mem_cs;
    logic [31:0] mem_r_data = 32'd0;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int cs_count = 0;
    int wr_count = 0;
    logic [31:0] mem [1024];
    logic [32:0] exp_q[$];

    load_store_unit #(.ADDR_W(10), .DATA_LEN(32)) dut (
        .d_clk(d_clk), .d_rst(d_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_rw_en(mem_rw_en),
        .mem_cs(mem_cs), .mem_r_data(mem_r_data), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 d_clk = ~d_clk;

    // data_memory model: registered read, write on chip-select with rw_en
    always @(posedge d_clk) begin
        if (mem_cs) begin
            cs_count <= cs_count + 1;
            if (mem_rw_en) begin
                mem[mem_addr] <= mem_w_data;
                wr_count <= wr_count + 1;
            end else begin
                mem_r_data <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request starting at a negedge; returns at the negedge where
    // rsp_valid is seen. lat = number of negedges after the accept edge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int lat);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge d_clk);
        #1 req_valid = 1'b0;
        lat = 0; rd = 32'hx; er = 1'bx;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge d_clk);
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
            end
        end
        if (lat == 0) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, f3, addr, 32'd0, rd, er, lat);
        check({tag, "_data"}, rd, exp);
        check({tag, "_err"}, {31'd0, er}, 32'd0);
        check({tag, "_lat"}, lat, 32'd3);
    endtask

    task automatic err_chk(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
        logic [31:0] rd; logic er; int lat; int cs0;
        cs0 = cs_count;
        do_req(we, f3, addr, 32'hFFFF_FFFF, rd, er, lat);
        check({tag, "_err"}, {31'd0, er}, 32'd1);
        check({tag, "_data"}, rd, 32'd0);
        check({tag, "_lat"}, lat, 32'd2);
        check({tag, "_no_cs"}, cs_count, cs0);
    endtask

    // back-to-back table: {we, funct3, addr, wdata, exp_err, exp_rdata}
    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t b2b [4];

    initial begin
        logic [31:0] rd; logic er; int lat; int wr0; int got; int idx; int cyc;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        // reset values
        #12;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
        check("rst_mem_rw_en", {31'd0, mem_rw_en}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_mem_w_data", mem_w_data, 32'd0);
        @(negedge d_clk) d_rst = 1'b0;
        @(negedge d_clk);

        // SW then LW
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("sw_lat", lat, 32'd2);
        check("sw_rdata", rd, 32'd0);
        check("sw_err", {31'd0, er}, 32'd0);
        check("sw_mem_word4", mem[4], 32'hDEADBEEF);
        load_chk("lw", 3'b010, 32'h10, 32'hDEADBEEF);
        @(negedge d_clk);
        check("rsp_hold", rsp_rdata, 32'hDEADBEEF);
        check("rsp_pulse", {31'd0, rsp_valid}, 32'd0);

        // sub-word loads and address wrap
        load_chk("lb", 3'b000, 32'h13, 32'hFFFFFFDE);
        load_chk("lbu", 3'b100, 32'h13, 32'h000000DE);
        load_chk("lh", 3'b001, 32'h10, 32'hFFFFBEEF);
        load_chk("lhu", 3'b101, 32'h12, 32'h0000DEAD);
        load_chk("lb_lane1", 3'b000, 32'h11, 32'hFFFFFFBE);
        load_chk("lw_wrap", 3'b010, 32'h0000_1010, 32'hDEADBEEF);

        // read-modify-write stores
        do_req(1'b1, 3'b000, 32'h11, 32'h12345677, rd, er, lat);
        check("sb_lat", lat, 32'd4);
        check("sb_err", {31'd0, er}, 32'd0);
        check("sb_word4", mem[4], 32'hDEAD77EF);
        do_req(1'b1, 3'b001, 32'h12, 32'hAAAA5555, rd, er, lat);
        check("sh_lat", lat, 32'd4);
        check("sh_rdata", rd, 32'd0);
        check("sh_word4", mem[4], 32'h555577EF);

        // errors
        err_chk("lw_mis", 1'b0, 3'b010, 32'h11);
        err_chk("sh_mis", 1'b1, 3'b001, 32'h13);
        err_chk("ld_f3_011", 1'b0, 3'b011, 32'h10);
        err_chk("st_f3_100", 1'b1, 3'b100, 32'h10);

        // reset during MERGE of an SB
        wr0 = wr_count;
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h11;
        req_valid = 1'b1;
        @(posedge d_clk);
        #1 req_valid = 1'b0;
        @(posedge d_clk);
        #1;
        check("merge_state", {29'd0, dbg_state}, 32'd4);
        d_rst = 1'b1;
        #1;
        check("abort_mem_cs", {31'd0, mem_cs}, 32'd0);
        check("abort_rw_en", {31'd0, mem_rw_en}, 32'd0);
        check("abort_w_data", mem_w_data, 32'd0);
        check("abort_addr", {22'd0, mem_addr}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rsp_rdata", rsp_rdata, 32'd0);
        check("abort_state", {29'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge d_clk);
        d_rst = 1'b0;
        repeat (4) @(negedge d_clk);
        check("abort_no_write", wr_count, wr0);
        check("abort_word4", mem[4], 32'h555577EF);

        // back-to-back with req_valid held high
        b2b[0] = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h555577EF};
        b2b[1] = '{1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0};
        b2b[2] = '{1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D};
        b2b[3] = '{1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 32'h0};
        idx = 0; got = 0; cyc = 0;
        req_we = b2b[0].we; req_funct3 = b2b[0].f3; req_addr = b2b[0].addr;
        req_wdata = b2b[0].wd; req_valid = 1'b1;
        while (got < 4 && cyc < 60) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("b2b_rdata", rsp_rdata, e[31:0]);
                    check("b2b_err", {31'd0, rsp_err}, {31'd0, e[32]});
                end
                if (idx < 4) check("b2b_ready_on_rsp", {31'd0, req_ready}, 32'd1);
                got++;
            end
            if (req_ready && idx < 4) begin
                exp_q.push_back({b2b[idx].exp_err, b2b[idx].exp_rd});
                idx++;
            end
            @(posedge d_clk);
            #1;
            if (idx < 4) begin
                req_we = b2b[idx].we; req_funct3 = b2b[idx].f3;
                req_addr = b2b[idx].addr; req_wdata = b2b[idx].wd;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge d_clk);
            cyc++;
        end
        check("b2b_rsp_count", got, 32'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge d_clk);
            if (rsp_valid) check("b2b_extra_rsp", 32'd1, 32'd0);
        end
        check("b2b_queue_empty", exp_q.size(), 32'd0);
        check("b2b_word8", mem[8], 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
